// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte-lane stores, registered sign/zero-extending loads, self-clearing sweep.
// Optional DMEM_WRITE_THROUGH_EN: same-cycle read+write to a word returns the merged new word.
module data_mem_ctrl #(
   parameter int B = 32,
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_mem_read,
   input  logic         i_mem_write,
   input  logic [1:0]   i_bhw,
   input  logic         i_unsigned,
   input  logic [W+1:0] i_addr,
   input  logic [B-1:0] i_data,
   input  logic [W-1:0] i_debug_addr,
   output logic [B-1:0] o_data,
   output logic         o_data_valid,
   output logic         o_misalign,
   output logic         o_busy,
   output logic [B-1:0] o_debug_mem
);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t       r_state, w_state_nxt;
   logic [W-1:0] r_cnt;
   logic [B-1:0] r_mem [2**W];

   logic [W-1:0] w_word;
   logic         w_misal_addr, w_misal, w_do_rd, w_do_wr;
   logic [3:0]   w_wr_mask;
   logic [B-1:0] w_wr_data, w_old_word, w_merged, w_rd_word, w_load_val;
   logic [7:0]   w_byte;
   logic [15:0]  w_half;

   assign w_word      = i_addr[W+1:2];
   assign w_old_word  = r_mem[w_word];
   assign o_debug_mem = r_mem[i_debug_addr];
   assign o_busy      = (r_state == S_CLEAR);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_CLEAR) r_cnt <= r_cnt + W'(1);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_misal_addr = 1'b0;
      w_misal      = 1'b0;
      w_do_rd      = 1'b0;
      w_do_wr      = 1'b0;
      if (r_state == S_CLEAR) begin
         if (r_cnt == '1) w_state_nxt = S_RUN;
      end else begin
         if (i_bhw == 2'b01)  w_misal_addr = i_addr[0];
         else if (i_bhw[1])   w_misal_addr = |i_addr[1:0];
         w_misal = (i_mem_read | i_mem_write) & w_misal_addr;
         w_do_rd = i_mem_read  & ~w_misal_addr;
         w_do_wr = i_mem_write & ~w_misal_addr;
      end
   end

   // Store data is replicated across lanes so the mask alone selects what lands.
   always_comb begin
      w_wr_mask = 4'b1111;
      w_wr_data = i_data;
      case (i_bhw)
         2'b00: begin
            w_wr_mask = 4'b0001 << i_addr[1:0];
            w_wr_data = {4{i_data[7:0]}};
         end
         2'b01: begin
            w_wr_mask = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wr_data = {2{i_data[15:0]}};
         end
         default: ;
      endcase
      for (int unsigned k = 0; k < 4; k++)
         w_merged[8*k +: 8] = w_wr_mask[k] ? w_wr_data[8*k +: 8] : w_old_word[8*k +: 8];
   end

   always_comb begin
`ifdef DMEM_WRITE_THROUGH_EN
      w_rd_word = w_do_wr ? w_merged : w_old_word;
`else
      w_rd_word = w_old_word;
`endif
      case (i_addr[1:0])
         2'b00:   w_byte = w_rd_word[7:0];
         2'b01:   w_byte = w_rd_word[15:8];
         2'b10:   w_byte = w_rd_word[23:16];
         default: w_byte = w_rd_word[31:24];
      endcase
      w_half = i_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      case (i_bhw)
         2'b00:   w_load_val = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         2'b01:   w_load_val = {{16{~i_unsigned & w_half[15]}}, w_half};
         default: w_load_val = w_rd_word;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (r_state == S_CLEAR) r_mem[r_cnt]  <= '0;
      else if (w_do_wr)       r_mem[w_word] <= w_merged;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data       <= '0;
         o_data_valid <= 1'b0;
         o_misalign   <= 1'b0;
      end else begin
         o_data_valid <= w_do_rd;
         o_misalign   <= w_misal;
         if (w_do_rd) o_data <= w_load_val;
      end
   end

endmodule
